softex_y_buffer_merge: RTL and testbench
========================================

# softex_y_buffer_merge

Loop-aware merge buffer on the SoftEx output datapath. It is the counterpart of the x-buffer replay stage: the x-buffer issues one stored word `num_loops` times, and this block collapses `num_loops` consecutive input beats into one output word. Beats are merged byte-wise under their strobes. The merged word is pushed into a small output FIFO ahead of the streamer sink. With merging disabled the block behaves as a plain FIFO.

## Interface
Parameters:
- `DATA_WIDTH`, default `DATA_W - 32`: stream data width.
- `STRB_WIDTH`, default `DATA_WIDTH / 8`: strobe width.
- `DEPTH`, default 2: output FIFO depth.
- `CNT_WIDTH`, default `BUF_CNT_WIDTH`: beat counter width.
- `LATCH_BUFFER`, default `USE_LATCH_BUF`: use a latch-based FIFO.

Ports (reset `rst_ni`, asynchronous, active-low; clock `clk_i`):
- `clk_i`  in  1  clock
- `rst_ni`  in  1  async active-low reset
- `clear_i`  in  1  synchronous soft clear
- `ctrl_i`  in  `y_buffer_ctrl_t`  `{merge, num_loops[CNT_WIDTH]}`
- `flags_o`  out  `y_buffer_flags_t`  `{busy, beat_cnt[CNT_WIDTH]}`
- `buffer_i`  sink  `hwpe_stream_intf_stream(DATA_WIDTH)`  partial-result beats
- `buffer_o`  source  `hwpe_stream_intf_stream(DATA_WIDTH)`  merged words

## Operation
- **State.** `acc_data[DATA_WIDTH]`, `acc_strb[STRB_WIDTH]`, `beat_cnt[CNT_WIDTH]`. All reset to 0.
- **Effective group length.** `L = (merge && num_loops > 1) ? num_loops : 1`.
- **Last beat.** `last = (beat_cnt + 1 == L)`, compared at `CNT_WIDTH`. `beat_cnt` never wraps because it clears on `last`.
- **Merge function.** For each byte b: `m_data[b] = buffer_i.strb[b] ? buffer_i.data[b] : acc_data[b]`. `m_strb = acc_strb | buffer_i.strb`. A later beat overrides earlier bytes.
- **Input ready.** `buffer_i.ready = last ? fifo_push.ready : 1`. Non-last beats are always absorbed into the accumulator.
- **Handshake on a non-last beat.** `acc <= m`, `beat_cnt++`.
- **Handshake on the last beat.** FIFO push of `{m_data, m_strb}` in the same cycle. `acc <= 0`, `beat_cnt <= 0`.
- **Pass-through.** When `L == 1`, every beat is last, so input goes straight to the FIFO. Data is unchanged because `acc` is 0 and merged under the input's own strobe.
- **Output.** `buffer_o` is driven directly by the FIFO pop port.
- **Control changes.** `ctrl_i` must be held stable while `flags_o.busy`. If `merge` falls or `num_loops` changes with `beat_cnt != 0`, the partial group is discarded: `acc` and `beat_cnt` are zeroed next cycle, no push occurs, and the current-cycle beat is not accepted.
- **`clear_i`.** Zeroes `acc` and `beat_cnt` and clears the FIFO. It has priority over any handshake in the same cycle.
- **Flags.** `busy = (beat_cnt != 0) | fifo not empty`. `beat_cnt` is the raw counter.

## Timing
- **Reset values.** `buffer_o.valid = 0`, `buffer_i.ready = 1`, `flags_o = 0`.
- **Latency.** Last input handshake to `buffer_o.valid` is the FIFO latency: 1 cycle for `hwpe_stream_fifo`. Non-last beats produce no output.
- **Throughput.** One input beat per cycle while the FIFO is not full. One merged word per L input cycles.
- **FIFO full.** Non-last beats are still accepted. The last beat stalls (`ready = 0`) until a pop frees a slot. `acc` is held unchanged during the stall.
- **Simultaneous pop and last-beat push with a full FIFO.** Accepted only if the FIFO's push ready reflects the same-cycle pop; the standard FIFO gives no such guarantee, so the push is simply not accepted.
- **Data stability.** `buffer_o.data`, `strb` and `valid` are stable while `valid & ~ready`, as the FIFO guarantees.
- **Reset mid-group.** A partial word is lost and nothing is emitted.

## Structure
- **Shared package (`softex_pkg`).**
  - `y_buffer_ctrl_t` and `y_buffer_flags_t`.
  - Reuse `BUF_CNT_WIDTH` and `USE_LATCH_BUF`.
- **Sub-modules.**
  - One instance of `hwpe_stream_fifo` as the output buffer.
  - The merge/accumulator datapath stays in the top module.
  - A new sub-module is not warranted.
- **Size.** About 150 lines.

## Test plan
- **Pass-through.** `merge=0`, 4 beats `0x11..`, `0x22..`, `0x33..`, `0x44..` with full strobe, sink always ready. Response: same 4 words in order, each 1 cycle after input.
- **Merge of 4 beats.** `merge=1`, `num_loops=4`, beats with strobes `0x000F`, `0x00F0`, `0x0F00`, `0xF000` carrying A/B/C/D. Response: one word with A/B/C/D in their respective bytes, strb `0xFFFF`. `beat_cnt` goes 0,1,2,3,0.
- **Override and degenerate lengths.** `num_loops=3`, three full-strobe beats X, Y, Z. Response: single output Z. Then `num_loops=0` or `1`: behaves as pass-through.
- **Backpressure.** `buffer_o.ready=0`, `num_loops=2`, `DEPTH=2`, 6 beats. Response: 2 words stored. The third group's last beat holds `buffer_i.ready=0`. Releasing ready drains 3 correct words with no loss.
- **Clear mid-group.** `num_loops=4`, 2 beats, then `clear_i`. Response: `beat_cnt=0`, no output. The next 4 beats yield one word containing only the new data.
- **Control change mid-group.** `num_loops=4`, 2 beats, then `merge` dropped. Response: partial group discarded, no push, `busy` falls, subsequent beats pass through.

Source files
------------

// File: rtl/softex_y_buffer_merge_pkg.sv
// Shared types and constants for the SoftEx y-buffer merge stage.
// Control and flag structs are sized by BUF_CNT_WIDTH.
package softex_y_buffer_merge_pkg;

  localparam int unsigned DATA_W        = 160;
  localparam int unsigned BUF_CNT_WIDTH = 8;
  localparam bit          USE_LATCH_BUF = 1'b0;

  typedef struct packed {
    logic                     merge;
    logic [BUF_CNT_WIDTH-1:0] num_loops;
  } y_buffer_ctrl_t;

  typedef struct packed {
    logic                     busy;
    logic [BUF_CNT_WIDTH-1:0] beat_cnt;
  } y_buffer_flags_t;

endpackage

// File: rtl/softex_y_buffer_merge_if.sv
// Valid/ready stream with byte strobes, used on both sides of the merge buffer.
interface softex_y_buffer_merge_if #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) ();

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport master (output valid, output data, output strb, input  ready);
  modport slave  (input  valid, input  data, input  strb, output ready);

endinterface

// File: rtl/softex_y_buffer_merge_fifo.sv
// Output FIFO for merged words: one cycle push-to-pop latency, push ready
// depends only on occupancy (a same-cycle pop does not free a slot).
module softex_y_buffer_merge_fifo #(
  parameter int unsigned DATA_WIDTH   = 128,
  parameter int unsigned STRB_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned DEPTH        = 2,
  parameter bit          LATCH_BUFFER = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  softex_y_buffer_merge_if.slave  push_i,
  softex_y_buffer_merge_if.master pop_o,
  output logic                    empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned EW = DATA_WIDTH + STRB_WIDTH;

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_cnt;
  logic          w_push, w_pop;

  // Storage is flop-based for either setting of LATCH_BUFFER.
  logic w_unused_latch_buf;
  assign w_unused_latch_buf = LATCH_BUFFER;

  assign push_i.ready = (r_cnt != CW'(DEPTH));
  assign pop_o.valid  = (r_cnt != '0);
  assign {pop_o.data, pop_o.strb} = r_mem[r_rptr];
  assign empty_o      = (r_cnt == '0);

  assign w_push = push_i.valid & push_i.ready;
  assign w_pop  = pop_o.valid & pop_o.ready;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= {push_i.data, push_i.strb};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (clear_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= (r_wptr == AW'(DEPTH - 1)) ? '0 : r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == AW'(DEPTH - 1)) ? '0 : r_rptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + CW'(1);
      end else if (!w_push && w_pop) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/softex_y_buffer_merge.sv
// Collapses groups of num_loops input beats into one byte-merged word and
// queues it in a small output FIFO; with merging off it is a plain FIFO.
module softex_y_buffer_merge
  import softex_y_buffer_merge_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DATA_W - 32,
  parameter int unsigned STRB_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned CNT_WIDTH    = BUF_CNT_WIDTH,
  parameter bit          LATCH_BUFFER = USE_LATCH_BUF
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  y_buffer_ctrl_t          ctrl_i,
  output y_buffer_flags_t         flags_o,
  softex_y_buffer_merge_if.slave  buffer_i,
  softex_y_buffer_merge_if.master buffer_o
);

  logic [DATA_WIDTH-1:0] r_acc_data;
  logic [STRB_WIDTH-1:0] r_acc_strb;
  logic [CNT_WIDTH-1:0]  r_beat_cnt;
  y_buffer_ctrl_t        r_ctrl;

  logic [CNT_WIDTH-1:0]  w_num_loops, w_len;
  logic                  w_last, w_discard, w_hs, w_fifo_empty;
  logic [DATA_WIDTH-1:0] w_m_data;
  logic [STRB_WIDTH-1:0] w_m_strb;

  softex_y_buffer_merge_if #(
    .DATA_WIDTH (DATA_WIDTH),
    .STRB_WIDTH (STRB_WIDTH)
  ) w_fifo_push ();

  assign w_num_loops = CNT_WIDTH'(ctrl_i.num_loops);
  assign w_len       = (ctrl_i.merge && (w_num_loops > CNT_WIDTH'(1))) ? w_num_loops
                                                                        : CNT_WIDTH'(1);
  assign w_last      = ((r_beat_cnt + CNT_WIDTH'(1)) == w_len);
  // A control change with a partial group pending drops the group this cycle.
  assign w_discard   = (r_ctrl != ctrl_i) && (r_beat_cnt != '0);

  always_comb begin
    w_m_data = r_acc_data;
    for (int b = 0; b < int'(STRB_WIDTH); b++) begin
      if (buffer_i.strb[b]) begin
        w_m_data[b*8 +: 8] = buffer_i.data[b*8 +: 8];
      end
    end
  end
  assign w_m_strb = r_acc_strb | buffer_i.strb;

  assign buffer_i.ready    = w_discard ? 1'b0 : (w_last ? w_fifo_push.ready : 1'b1);
  assign w_hs              = buffer_i.valid & buffer_i.ready;

  assign w_fifo_push.valid = buffer_i.valid & w_last & ~w_discard;
  assign w_fifo_push.data  = w_m_data;
  assign w_fifo_push.strb  = w_m_strb;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_acc_data <= '0;
      r_acc_strb <= '0;
      r_beat_cnt <= '0;
      r_ctrl     <= '0;
    end else begin
      r_ctrl <= ctrl_i;
      if (clear_i || w_discard || (w_hs && w_last)) begin
        r_acc_data <= '0;
        r_acc_strb <= '0;
        r_beat_cnt <= '0;
      end else if (w_hs) begin
        r_acc_data <= w_m_data;
        r_acc_strb <= w_m_strb;
        r_beat_cnt <= r_beat_cnt + CNT_WIDTH'(1);
      end
    end
  end

  softex_y_buffer_merge_fifo #(
    .DATA_WIDTH   (DATA_WIDTH),
    .STRB_WIDTH   (STRB_WIDTH),
    .DEPTH        (DEPTH),
    .LATCH_BUFFER (LATCH_BUFFER)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (w_fifo_push),
    .pop_o   (buffer_o),
    .empty_o (w_fifo_empty)
  );

  assign flags_o.busy     = (r_beat_cnt != '0) | ~w_fifo_empty;
  assign flags_o.beat_cnt = BUF_CNT_WIDTH'(r_beat_cnt);

endmodule

// File: tb/tb_softex_y_buffer_merge.sv
// Directed bench for softex_y_buffer_merge: pass-through, merging, overrides,
// backpressure, clear and control-change discard.
module tb_softex_y_buffer_merge;
  import softex_y_buffer_merge_pkg::*;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            clear_i;
  y_buffer_ctrl_t  ctrl_i;
  y_buffer_flags_t flags_o;

  softex_y_buffer_merge_if #(.DATA_WIDTH(128)) in_if ();
  softex_y_buffer_merge_if #(.DATA_WIDTH(128)) out_if ();

  softex_y_buffer_merge #(
    .DATA_WIDTH   (128),
    .STRB_WIDTH   (16),
    .DEPTH        (2),
    .CNT_WIDTH    (8),
    .LATCH_BUFFER (1'b0)
  ) u_dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (clear_i),
    .ctrl_i   (ctrl_i),
    .flags_o  (flags_o),
    .buffer_i (in_if),
    .buffer_o (out_if)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [127:0] out_data_q [$];
  logic [15:0]  out_strb_q [$];
  int           out_cyc_q  [$];
  int           in_cyc_q   [$];

  always @(posedge clk_i) cyc <= cyc + 1;

  // Handshakes are decided at the next posedge; inputs only move just after posedges.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (in_if.valid && in_if.ready) in_cyc_q.push_back(cyc);
      if (out_if.valid && out_if.ready) begin
        out_data_q.push_back(out_if.data);
        out_strb_q.push_back(out_if.strb);
        out_cyc_q.push_back(cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic clear_queues();
    out_data_q.delete();
    out_strb_q.delete();
    out_cyc_q.delete();
    in_cyc_q.delete();
  endtask

  task automatic idle(input int n);
    in_if.valid = 1'b0;
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Leaves valid asserted so consecutive calls produce back-to-back beats.
  task automatic send_beat(input logic [127:0] d, input logic [15:0] s);
    bit ok;
    ok = 1'b0;
    in_if.data  = d;
    in_if.strb  = s;
    in_if.valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (in_if.ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk_i);
    #1;
    if (!ok) check_eq("send_timeout", 128'd0, 128'd1);
  endtask

  logic [127:0] exp_w [4];

  initial begin
    rst_ni       = 1'b0;
    clear_i      = 1'b0;
    ctrl_i       = '0;
    in_if.valid  = 1'b0;
    in_if.data   = '0;
    in_if.strb   = '0;
    out_if.ready = 1'b1;
    #3;
    check_eq("rst_out_valid", 128'(out_if.valid), 128'd0);
    check_eq("rst_in_ready", 128'(in_if.ready), 128'd1);
    check_eq("rst_flags", 128'(flags_o), 128'd0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    idle(2);

    // Pass-through
    clear_queues();
    send_beat({16{8'h11}}, 16'hFFFF);
    send_beat({16{8'h22}}, 16'hFFFF);
    send_beat({16{8'h33}}, 16'hFFFF);
    send_beat({16{8'h44}}, 16'hFFFF);
    idle(4);
    exp_w[0] = {16{8'h11}};
    exp_w[1] = {16{8'h22}};
    exp_w[2] = {16{8'h33}};
    exp_w[3] = {16{8'h44}};
    check_eq("pt_count", 128'(out_data_q.size()), 128'd4);
    for (int i = 0; i < 4 && i < out_data_q.size() && i < in_cyc_q.size(); i++) begin
      check_eq("pt_data", out_data_q[i], exp_w[i]);
      check_eq("pt_latency", 128'(out_cyc_q[i] - in_cyc_q[i]), 128'd1);
    end

    // Merge of 4 beats
    clear_queues();
    ctrl_i.merge     = 1'b1;
    ctrl_i.num_loops = 8'd4;
    idle(1);
    check_eq("m4_cnt0", 128'(flags_o.beat_cnt), 128'd0);
    send_beat({16{8'hA1}}, 16'h000F);
    check_eq("m4_cnt1", 128'(flags_o.beat_cnt), 128'd1);
    send_beat({16{8'hB2}}, 16'h00F0);
    check_eq("m4_cnt2", 128'(flags_o.beat_cnt), 128'd2);
    send_beat({16{8'hC3}}, 16'h0F00);
    check_eq("m4_cnt3", 128'(flags_o.beat_cnt), 128'd3);
    send_beat({16{8'hD4}}, 16'hF000);
    check_eq("m4_cnt_wrap", 128'(flags_o.beat_cnt), 128'd0);
    idle(4);
    check_eq("m4_count", 128'(out_data_q.size()), 128'd1);
    if (out_data_q.size() > 0) begin
      check_eq("m4_data", out_data_q[0], 128'hD4D4D4D4_C3C3C3C3_B2B2B2B2_A1A1A1A1);
      check_eq("m4_strb", 128'(out_strb_q[0]), 128'hFFFF);
    end

    // Override, then degenerate lengths 1 and 0
    clear_queues();
    ctrl_i.num_loops = 8'd3;
    idle(1);
    send_beat({16{8'hE1}}, 16'hFFFF);
    send_beat({16{8'hE2}}, 16'hFFFF);
    send_beat({16{8'hE3}}, 16'hFFFF);
    ctrl_i.num_loops = 8'd1;
    send_beat({16{8'h5A}}, 16'hFFFF);
    send_beat({16{8'h5B}}, 16'h00FF);
    ctrl_i.num_loops = 8'd0;
    send_beat({16{8'h5C}}, 16'hFFFF);
    idle(4);
    exp_w[0] = {16{8'hE3}};
    exp_w[1] = {16{8'h5A}};
    exp_w[2] = {64'h0, {8{8'h5B}}};
    exp_w[3] = {16{8'h5C}};
    check_eq("ov_count", 128'(out_data_q.size()), 128'd4);
    for (int i = 0; i < 4 && i < out_data_q.size(); i++) begin
      check_eq("ov_data", out_data_q[i], exp_w[i]);
    end

    // Backpressure with DEPTH=2, groups of 2
    clear_queues();
    ctrl_i.num_loops = 8'd2;
    out_if.ready     = 1'b0;
    idle(1);
    send_beat({16{8'h11}}, 16'h00FF);
    send_beat({16{8'h21}}, 16'hFF00);
    send_beat({16{8'h12}}, 16'h00FF);
    send_beat({16{8'h22}}, 16'hFF00);
    send_beat({16{8'h13}}, 16'h00FF);
    in_if.data  = {16{8'h23}};
    in_if.strb  = 16'hFF00;
    in_if.valid = 1'b1;
    @(negedge clk_i);
    check_eq("bp_stall_ready", 128'(in_if.ready), 128'd0);
    check_eq("bp_stall_cnt", 128'(flags_o.beat_cnt), 128'd1);
    repeat (2) @(negedge clk_i);
    check_eq("bp_stall_hold", 128'(in_if.ready), 128'd0);
    check_eq("bp_stored", 128'(in_cyc_q.size()), 128'd5);
    @(posedge clk_i);
    #1 out_if.ready = 1'b1;
    send_beat({16{8'h23}}, 16'hFF00);
    idle(6);
    exp_w[0] = {{8{8'h21}}, {8{8'h11}}};
    exp_w[1] = {{8{8'h22}}, {8{8'h12}}};
    exp_w[2] = {{8{8'h23}}, {8{8'h13}}};
    check_eq("bp_count", 128'(out_data_q.size()), 128'd3);
    for (int i = 0; i < 3 && i < out_data_q.size(); i++) begin
      check_eq("bp_data", out_data_q[i], exp_w[i]);
    end

    // Clear mid-group
    clear_queues();
    ctrl_i.num_loops = 8'd4;
    idle(1);
    send_beat({16{8'h55}}, 16'h000F);
    send_beat({16{8'h66}}, 16'h00F0);
    in_if.valid = 1'b0;
    clear_i     = 1'b1;
    @(posedge clk_i);
    #1 clear_i = 1'b0;
    check_eq("clr_cnt", 128'(flags_o.beat_cnt), 128'd0);
    check_eq("clr_busy", 128'(flags_o.busy), 128'd0);
    send_beat({16{8'h77}}, 16'h0100);
    send_beat({16{8'h88}}, 16'h0200);
    send_beat({16{8'h99}}, 16'h0C00);
    check_eq("clr_no_out", 128'(out_data_q.size()), 128'd0);
    send_beat({16{8'hAA}}, 16'hF000);
    idle(4);
    check_eq("clr_count", 128'(out_data_q.size()), 128'd1);
    if (out_data_q.size() > 0) begin
      check_eq("clr_data", out_data_q[0], 128'hAAAAAAAA_9999_88_77_0000000000000000);
      check_eq("clr_strb", 128'(out_strb_q[0]), 128'hFF00);
    end

    // Control change mid-group
    clear_queues();
    send_beat({16{8'h12}}, 16'hFFFF);
    send_beat({16{8'h34}}, 16'hFFFF);
    in_if.valid = 1'b0;
    check_eq("cc_cnt2", 128'(flags_o.beat_cnt), 128'd2);
    check_eq("cc_busy1", 128'(flags_o.busy), 128'd1);
    ctrl_i.merge = 1'b0;
    @(negedge clk_i);
    check_eq("cc_ready_low", 128'(in_if.ready), 128'd0);
    @(posedge clk_i);
    #1;
    check_eq("cc_cnt0", 128'(flags_o.beat_cnt), 128'd0);
    check_eq("cc_busy0", 128'(flags_o.busy), 128'd0);
    check_eq("cc_no_push", 128'(out_data_q.size()), 128'd0);
    send_beat({16{8'h56}}, 16'hFFFF);
    send_beat({16{8'h78}}, 16'hFFFF);
    idle(4);
    check_eq("cc_count", 128'(out_data_q.size()), 128'd2);
    if (out_data_q.size() > 1) begin
      check_eq("cc_data0", out_data_q[0], {16{8'h56}});
      check_eq("cc_data1", out_data_q[1], {16{8'h78}});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
